// File: rtl/proc_pkg.sv
// Shared processor-block package.
// Holds the FSM state encoding used by the sequential divider and the
// default operand width used by div and div_step.
package proc_pkg;

    localparam int DEFAULT_N_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// The partial remainder is shifted left and the next dividend bit enters at
// the bottom. If the divisor fits, it is subtracted and the quotient bit is 1.
// Otherwise the shifted value is kept (restored) and the quotient bit is 0.
//
// Ports:
//   rem_in   [N_BIT-1:0]  partial remainder before this step (always < divisor)
//   divisor  [N_BIT-1:0]  divisor magnitude
//   dvd_bit               next dividend bit, MSB first
//   rem_out  [N_BIT-1:0]  partial remainder after this step
//   q_bit                 quotient bit produced by this step
module div_step
    import proc_pkg::*;
#(
    parameter int N_BIT = DEFAULT_N_BIT
) (
    input  logic [N_BIT-1:0] rem_in,
    input  logic [N_BIT-1:0] divisor,
    input  logic             dvd_bit,
    output logic [N_BIT-1:0] rem_out,
    output logic             q_bit
);

    logic [N_BIT:0] shifted;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        // The true difference is below the divisor, so N_BIT-bit modular
        // subtraction is exact even when shifted has its top bit set.
        rem_out = q_bit ? (shifted[N_BIT-1:0] - divisor) : shifted[N_BIT-1:0];
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   CALC  | N_BIT shift-subtract steps on operand magnitudes, busy=1
//   DONE  | one cycle: results updated, valid=1; start may be accepted here
//
// Optional feature: define DIV_SIGNED_EN to enable two's-complement signed
// division selected by div_type. Without it div_type is ignored and all
// operands are treated as unsigned. The sign-correction logic is not built.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   start                    division request, accepted when busy=0
//   A, B        [N_BIT-1:0]  dividend, divisor (latched on accepted start)
//   div_type                 0 unsigned, 1 signed (only with DIV_SIGNED_EN)
//   busy                     high in CALC
//   valid                    one-cycle pulse in DONE
//   quotient    [RES_SIZE-1:0]
//   remainder   [RES_SIZE-1:0]
//   div_by_zero              last result had B=0
module div
    import proc_pkg::*;
#(
    parameter int N_BIT    = DEFAULT_N_BIT,
    parameter int RES_SIZE = N_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_BIT-1:0]    A,
    input  logic [N_BIT-1:0]    B,
    input  logic                div_type,
    output logic                busy,
    output logic                valid,
    output logic [RES_SIZE-1:0] quotient,
    output logic [RES_SIZE-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CW = $clog2(N_BIT + 1);
    localparam logic [N_BIT-1:0] ONE_N = N_BIT'(1);
    // Bits above the N_BIT result, used for sign extension into RES_SIZE.
    localparam logic [RES_SIZE-1:0] HI_MASK = ~RES_SIZE'({N_BIT{1'b1}});

    state_t            state;
    logic [N_BIT-1:0]  a_lat;
    logic [N_BIT-1:0]  dvd_sh;
    logic [N_BIT-1:0]  dvs;
    logic [N_BIT-1:0]  rem_r;
    logic [N_BIT-1:0]  q_sh;
    logic [CW-1:0]     cnt;
    logic              b_zero;

    logic [N_BIT-1:0]  a_mag;
    logic [N_BIT-1:0]  b_mag;
    logic [N_BIT-1:0]  step_rem;
    logic              step_q;
    logic [N_BIT-1:0]  q_fin;
    logic [N_BIT-1:0]  q_n;
    logic [N_BIT-1:0]  r_n;
    logic [RES_SIZE-1:0] q_res;
    logic [RES_SIZE-1:0] r_res;
    logic [RES_SIZE-1:0] a_res;

`ifdef DIV_SIGNED_EN
    logic signed_lat;
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;
`else
    logic unused_div_type;
    assign unused_div_type = div_type;
`endif

    assign busy = (state == CALC);

    // Operand magnitudes taken straight from the inputs; latched on accept.
    always_comb begin
`ifdef DIV_SIGNED_EN
        a_neg = div_type & A[N_BIT-1];
        b_neg = div_type & B[N_BIT-1];
        a_mag = a_neg ? (~A + ONE_N) : A;
        b_mag = b_neg ? (~B + ONE_N) : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    div_step #(
        .N_BIT (N_BIT)
    ) u_step (
        .rem_in  (rem_r),
        .divisor (dvs),
        .dvd_bit (dvd_sh[N_BIT-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign q_fin = {q_sh[N_BIT-2:0], step_q};

    // Final result as it will be registered on entry to DONE. Only
    // meaningful on the last CALC cycle.
    always_comb begin
        q_n = q_fin;
        r_n = step_rem;
`ifdef DIV_SIGNED_EN
        if (neg_q) q_n = ~q_fin + ONE_N;
        if (neg_r) r_n = ~step_rem + ONE_N;
`endif
        q_res = RES_SIZE'(q_n);
        r_res = RES_SIZE'(r_n);
        a_res = RES_SIZE'(a_lat);
`ifdef DIV_SIGNED_EN
        if (signed_lat && q_n[N_BIT-1])   q_res = q_res | HI_MASK;
        if (signed_lat && r_n[N_BIT-1])   r_res = r_res | HI_MASK;
        if (signed_lat && a_lat[N_BIT-1]) a_res = a_res | HI_MASK;
`endif
        // Divide by zero: the restoring loop would already give all-ones
        // over the magnitude, but sign correction and the remainder must
        // not apply, so both are overridden here.
        if (b_zero) begin
            q_res = '1;
            r_res = a_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_lat       <= '0;
            dvd_sh      <= '0;
            dvs         <= '0;
            rem_r       <= '0;
            q_sh        <= '0;
            cnt         <= '0;
            b_zero      <= 1'b0;
`ifdef DIV_SIGNED_EN
            signed_lat  <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= CALC;
                        a_lat  <= A;
                        dvd_sh <= a_mag;
                        dvs    <= b_mag;
                        rem_r  <= '0;
                        b_zero <= (B == '0);
                        cnt    <= CW'(N_BIT - 1);
`ifdef DIV_SIGNED_EN
                        signed_lat <= div_type;
                        neg_q      <= a_neg ^ b_neg;
                        neg_r      <= a_neg;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem_r  <= step_rem;
                    q_sh   <= q_fin;
                    dvd_sh <= {dvd_sh[N_BIT-2:0], 1'b0};
                    if (cnt == '0) begin
                        state       <= DONE;
                        valid       <= 1'b1;
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= b_zero;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter N_BIT, default 4, operand width in bits.
REQ-002 SHALL have parameter RES_SIZE, default N_BIT, quotient and remainder width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a division; accepted only when busy=0.
REQ-006 SHALL have port A  input  N_BIT  dividend.
REQ-007 SHALL have port B  input  N_BIT  divisor.
REQ-008 SHALL have port div_type  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port valid  output  1  one-cycle pulse: result outputs are updated.
REQ-011 SHALL have port quotient  output  RES_SIZE  division result.
REQ-012 SHALL have port remainder  output  RES_SIZE  remainder.
REQ-013 SHALL have port div_by_zero  output  1  last result had B=0.

Function
REQ-014 SHALL implement FSM IDLE -> CALC on an accepted start, CALC -> DONE after N_BIT step cycles, DONE -> IDLE after one cycle; start is also accepted in DONE (DONE -> CALC).
REQ-015 SHALL latch A, B and div_type on accepted start; later input changes have no effect on the running division.
REQ-016 SHALL ignore start while busy=1: no restart, no change to the running division.
REQ-017 SHALL hold busy=1 in CALC only.
REQ-018 SHALL raise valid for exactly the DONE cycle: start sampled at edge t gives valid=1 during cycle t+N_BIT+1.
REQ-019 SHALL use restoring shift-subtract on magnitudes, one quotient bit per CALC cycle, MSB first.
REQ-020 SHALL, for signed operation, negate the quotient when sign(A) xor sign(B), and give the remainder the sign of A.
REQ-021 SHALL wrap the quotient modulo 2^N_BIT; signed most-negative / -1 gives quotient = most-negative and remainder = 0.
REQ-022 SHALL, when B=0, give quotient all ones, remainder = A and div_by_zero=1, with the same latency as a normal division.
REQ-023 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them until the next DONE or reset.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, go to IDLE and clear busy, valid, quotient, remainder and div_by_zero to 0.
REQ-025 SHALL abort any division in progress on reset, with no valid pulse.
REQ-026 SHALL give rst priority over start when both are high at the same edge.

Configuration
REQ-027 SHALL support signed division only when macro DIV_SIGNED_EN is defined; then div_type behaves as in REQ-008 and REQ-020.
REQ-028 SHALL, without DIV_SIGNED_EN, ignore div_type and treat all operands as unsigned; sign-correction logic is absent.

Structure
REQ-029 SHALL take its FSM state enum (IDLE, CALC, DONE) and its default width constant from the shared package proc_pkg.
REQ-030 SHALL place one shift-subtract-restore step in sub-module div_step: inputs partial remainder, divisor and next dividend bit; outputs new partial remainder and quotient bit.

Verification (N_BIT=4)
REQ-031 SHALL cover: unsigned A=13, B=3, start at cycle 0 -> valid at cycle 5, quotient=4, remainder=1, div_by_zero=0.
REQ-032 SHALL cover: signed A=1001 (-7), B=0010 (2) -> quotient=1101 (-3), remainder=1111 (-1).
REQ-033 SHALL cover: signed A=1000, B=1111 -> quotient=1000, remainder=0000.
REQ-034 SHALL cover: A=1001, B=0 -> quotient=1111, remainder=1001, div_by_zero=1, valid at cycle 5.
REQ-035 SHALL cover: second start at cycle 2 with different operands -> ignored; first result arrives at cycle 5; a start in the DONE cycle is accepted, valid at cycle 10.
REQ-036 SHALL cover: rst at cycle 3 mid-CALC -> no valid pulse, all outputs 0, then a fresh 13/3 completes correctly.
